vga_debug_snapshot: RTL and testbench

//  Frame-coherent capture of CPU debug state (10 x 16-bit registers + PC) for the VGA renderer.

---
 rtl/vga_debug_snapshot_pkg.sv | 20 ++
 rtl/vga_debug_snapshot_if.sv | 31 +++
 rtl/vga_debug_snapshot_sync_edge.sv | 24 ++
 rtl/vga_debug_snapshot.sv | 148 ++++++++++++++
 tb/tb_vga_debug_snapshot.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_debug_snapshot_pkg.sv
// Shared definitions for the debug snapshot block: parameter defaults, FSM encoding, counter sizing.
package vga_debug_snapshot_pkg;

    localparam int   DEF_NREG      = 10;
    localparam int   DEF_RW        = 16;
    localparam int   DEF_WAIT_MAX  = 1024;
    localparam logic DEF_VS_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2
    } state_t;

    // Width of the post-frame-start wait counter; never below one bit.
    function automatic int wait_width(input int wmax);
        return (wmax > 1) ? $clog2(wmax) : 1;
    endfunction

endpackage

// File: rtl/vga_debug_snapshot_if.sv
// CPU/VGA side bundle of the debug snapshot block; master drives CPU state and sync, slave is the snapshot logic.
interface vga_debug_snapshot_if
    import vga_debug_snapshot_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int RW   = DEF_RW
);
    logic                 vgaVs;
    logic [NREG*RW-1:0]   regIn;
    logic [RW-1:0]        pcIn;
    logic                 cpuValid;
    logic                 freezeIn;
    logic [NREG*RW-1:0]   regOut;
    logic [RW-1:0]        pcOut;
    logic                 snapDone;
    logic                 stale;
    logic                 frozen;
    logic [15:0]          frameCnt;
    logic [NREG-1:0]      changedMask;

    modport master (
        output vgaVs, regIn, pcIn, cpuValid, freezeIn,
        input  regOut, pcOut, snapDone, stale, frozen, frameCnt, changedMask
    );

    modport slave (
        input  vgaVs, regIn, pcIn, cpuValid, freezeIn,
        output regOut, pcOut, snapDone, stale, frozen, frameCnt, changedMask
    );

endinterface

// File: rtl/vga_debug_snapshot_sync_edge.sv
// Registers vsync and flags the first cycle of the sync pulse (frame start).
// Latency: fs_o is combinational on the cycle vs_i enters the active level.
module vga_debug_snapshot_sync_edge
    import vga_debug_snapshot_pkg::*;
#(
    parameter logic VS_ACTIVE = DEF_VS_ACTIVE
)(
    input  logic clk50M,
    input  logic rst,
    input  logic vs_i,
    output logic fs_o
);

    logic vs_q;

    // Reset to the inactive level so a sync pulse already in progress at release counts as a frame start.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) vs_q <= ~VS_ACTIVE;
        else      vs_q <= vs_i;
    end

    assign fs_o = (vs_q != VS_ACTIVE) && (vs_i == VS_ACTIVE);

endmodule

// File: rtl/vga_debug_snapshot.sv
// Frame-coherent shadow of CPU debug registers + PC, loaded at vsync start on a cpuValid cycle.
// Capture lands on the edge cpuValid is sampled while armed; snapDone follows one cycle later; no backpressure.
// Optional DIFF_HIGHLIGHT_EN: per-register changed flags recorded at each capture, else changedMask is 0.
module vga_debug_snapshot
    import vga_debug_snapshot_pkg::*;
#(
    parameter int   NREG      = DEF_NREG,
    parameter int   RW        = DEF_RW,
    parameter int   WAIT_MAX  = DEF_WAIT_MAX,
    parameter logic VS_ACTIVE = DEF_VS_ACTIVE
)(
    input  logic              clk50M,
    input  logic              rst,
    vga_debug_snapshot_if.slave bus
);

    localparam int             WW        = wait_width(WAIT_MAX);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_MAX - 1);

    logic fs;

    vga_debug_snapshot_sync_edge #(.VS_ACTIVE(VS_ACTIVE)) u_sync_edge (
        .clk50M (clk50M),
        .rst    (rst),
        .vs_i   (bus.vgaVs),
        .fs_o   (fs)
    );

    state_t             state_q, state_d;
    logic [NREG*RW-1:0] reg_q, reg_d;
    logic [RW-1:0]      pc_q, pc_d;
    logic               stale_q, stale_d;
    logic               frozen_q, frozen_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [WW-1:0]      wait_q, wait_d;

    logic arm_clr, cap, tmo, refs, wait_inc, snap_done;
    logic wait_last;

    assign wait_last = (wait_q == WAIT_LAST);

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fs && !bus.freezeIn) state_d = ST_ARMED;
            ST_ARMED: begin
                if (bus.freezeIn)      state_d = ST_IDLE;
                else if (bus.cpuValid) state_d = ST_CAPT;
                else if (wait_last)    state_d = ST_IDLE;
            end
            ST_CAPT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Freeze outranks a coincident cpuValid, so a frozen display can never be overwritten.
    always_comb begin
        arm_clr   = 1'b0;
        cap       = 1'b0;
        tmo       = 1'b0;
        refs      = 1'b0;
        wait_inc  = 1'b0;
        snap_done = 1'b0;
        case (state_q)
            ST_IDLE:  arm_clr = fs && !bus.freezeIn;
            ST_ARMED: begin
                if (!bus.freezeIn) begin
                    if (bus.cpuValid)  cap      = 1'b1;
                    else if (wait_last) tmo     = 1'b1;
                    else if (fs)        refs    = 1'b1;
                    else                wait_inc = 1'b1;
                end
            end
            ST_CAPT:  snap_done = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        reg_d       = reg_q;
        pc_d        = pc_q;
        stale_d     = stale_q;
        wait_d      = wait_q;
        frozen_d    = bus.freezeIn;
        frame_cnt_d = frame_cnt_q + {15'd0, fs};
        if (cap) begin
            reg_d = bus.regIn;
            pc_d  = bus.pcIn;
        end
        if (cap)              stale_d = 1'b0;
        else if (tmo || refs) stale_d = 1'b1;
        if (arm_clr || refs)  wait_d = '0;
        else if (wait_inc)    wait_d = wait_q + WW'(1);
    end

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            reg_q       <= '0;
            pc_q        <= '0;
            stale_q     <= 1'b0;
            frozen_q    <= 1'b0;
            frame_cnt_q <= '0;
            wait_q      <= '0;
        end else begin
            reg_q       <= reg_d;
            pc_q        <= pc_d;
            stale_q     <= stale_d;
            frozen_q    <= frozen_d;
            frame_cnt_q <= frame_cnt_d;
            wait_q      <= wait_d;
        end
    end

`ifdef DIFF_HIGHLIGHT_EN
    logic [NREG-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (cap) begin
            for (int i = 0; i < NREG; i++) begin
                mask_d[i] = (bus.regIn[i*RW +: RW] != reg_q[i*RW +: RW]);
            end
        end
    end

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) mask_q <= '0;
        else      mask_q <= mask_d;
    end

    assign bus.changedMask = mask_q;
`else
    assign bus.changedMask = '0;
`endif

    assign bus.regOut   = reg_q;
    assign bus.pcOut    = pc_q;
    assign bus.snapDone = snap_done;
    assign bus.stale    = stale_q;
    assign bus.frozen   = frozen_q;
    assign bus.frameCnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_debug_snapshot.sv
// Bench for vga_debug_snapshot: directed scenarios then random frames, checked against a per-register reference model.
module tb_vga_debug_snapshot;

    localparam int NREG     = 10;
    localparam int RW       = 16;
    localparam int WAIT_MAX = 8;
    localparam int W        = NREG * RW;

    typedef logic [W-1:0] wv_t;

    typedef struct {
        wv_t             r;
        logic [RW-1:0]   p;
        logic [NREG-1:0] m;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    vga_debug_snapshot_if #(.NREG(NREG), .RW(RW)) bus ();

    vga_debug_snapshot #(
        .NREG(NREG), .RW(RW), .WAIT_MAX(WAIT_MAX), .VS_ACTIVE(1'b0)
    ) dut (
        .clk50M (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_snap = 0;
    snap_t exp_q[$];

    // Reference model state: one int per register, plain flags for the capture window.
    int m_reg[NREG];
    bit m_mask[NREG];
    int m_pc = 0, m_fc = 0, m_wcnt = 0;
    bit m_armed = 0, m_just = 0, m_stale = 0, m_frozen = 0;
    bit m_vs_prev = 1;

    task automatic chk(input string name, input wv_t act, input wv_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic wv_t pack_regs();
        wv_t r;
        r = '0;
        for (int i = 0; i < NREG; i++) r[i*RW +: RW] = m_reg[i][RW-1:0];
        return r;
    endfunction

    function automatic logic [NREG-1:0] pack_mask();
        logic [NREG-1:0] m;
        for (int i = 0; i < NREG; i++) m[i] = m_mask[i];
        return m;
    endfunction

    function automatic wv_t rnd_bus();
        wv_t r;
        r = '0;
        for (int i = 0; i < NREG; i++) r[i*RW +: RW] = RW'($urandom);
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = 0;
                m_mask[i] = 0;
            end
            m_pc = 0; m_fc = 0; m_wcnt = 0;
            m_armed = 0; m_just = 0; m_stale = 0; m_frozen = 0;
            m_vs_prev = 1;
        end else begin
            bit fs;
            snap_t s;
            fs = m_vs_prev && !bus.vgaVs;
            m_vs_prev = bus.vgaVs;
            m_frozen = bus.freezeIn;
            if (fs) m_fc = (m_fc + 1) % 65536;
            if (m_just) begin
                m_just = 0;
            end else if (!m_armed) begin
                if (fs && !bus.freezeIn) begin
                    m_armed = 1;
                    m_wcnt  = 0;
                end
            end else if (bus.freezeIn) begin
                m_armed = 0;
            end else if (bus.cpuValid) begin
                for (int i = 0; i < NREG; i++) begin
`ifdef DIFF_HIGHLIGHT_EN
                    m_mask[i] = (int'(bus.regIn[i*RW +: RW]) != m_reg[i]);
`endif
                    m_reg[i] = int'(bus.regIn[i*RW +: RW]);
                end
                m_pc = int'(bus.pcIn);
                m_stale = 0;
                m_armed = 0;
                m_just  = 1;
                s.r = pack_regs();
                s.p = RW'(m_pc);
                s.m = pack_mask();
                exp_q.push_back(s);
            end else if (m_wcnt == WAIT_MAX - 1) begin
                m_stale = 1;
                m_armed = 0;
            end else if (fs) begin
                m_stale = 1;
                m_wcnt  = 0;
            end else begin
                m_wcnt++;
            end
        end
    end

    // Scoreboard monitor: every snapDone consumes one predicted capture.
    always @(negedge clk) begin
        if (rst && bus.snapDone === 1'b1) begin
            snap_t s;
            n_snap++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL snap_unexpected: got snapDone=1 want no pending capture");
            end else begin
                s = exp_q.pop_front();
                chk("snap_regs", bus.regOut, s.r);
                chk("snap_pc", wv_t'(bus.pcOut), wv_t'(s.p));
                chk("snap_mask", wv_t'(bus.changedMask), wv_t'(s.m));
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_regOut", bus.regOut, pack_regs());
            chk("cyc_pcOut", wv_t'(bus.pcOut), wv_t'(m_pc));
            chk("cyc_stale", wv_t'(bus.stale), wv_t'(m_stale));
            chk("cyc_frozen", wv_t'(bus.frozen), wv_t'(m_frozen));
            chk("cyc_snapDone", wv_t'(bus.snapDone), wv_t'(m_just));
            chk("cyc_frameCnt", wv_t'(bus.frameCnt), wv_t'(m_fc));
            chk("cyc_mask", wv_t'(bus.changedMask), wv_t'(pack_mask()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_regOut"}, bus.regOut, '0);
        chk({tag, "_pcOut"}, wv_t'(bus.pcOut), '0);
        chk({tag, "_snapDone"}, wv_t'(bus.snapDone), '0);
        chk({tag, "_stale"}, wv_t'(bus.stale), '0);
        chk({tag, "_frozen"}, wv_t'(bus.frozen), '0);
        chk({tag, "_frameCnt"}, wv_t'(bus.frameCnt), '0);
        chk({tag, "_mask"}, wv_t'(bus.changedMask), '0);
    endtask

    task automatic capture_frame(input int dly);
        bus.vgaVs = 1'b0;
        cyc(1);
        bus.vgaVs = 1'b1;
        cyc(dly);
        bus.cpuValid = 1'b1;
        cyc(1);
        bus.cpuValid = 1'b0;
        cyc(1);
    endtask

    initial begin
        wv_t             r0;
        logic [RW-1:0]   p0;
        logic [15:0]     fc0;
        logic [NREG-1:0] exp_mask;
        int              ns0, len, pv, idx;

        bus.vgaVs = 1'b1; bus.regIn = '0; bus.pcIn = '0;
        bus.cpuValid = 1'b0; bus.freezeIn = 1'b0;

        #5 rst = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        // Basic capture with cpuValid arriving three cycles after vsync falls.
        bus.regIn = rnd_bus();
        bus.regIn[15:0] = 16'h1234;
        bus.pcIn = 16'h0040;
        bus.vgaVs = 1'b0;
        cyc(3);
        bus.vgaVs = 1'b1;
        bus.cpuValid = 1'b1;
        cyc(1);
        bus.cpuValid = 1'b0;
        chk("t2_reg0", wv_t'(bus.regOut[15:0]), wv_t'(16'h1234));
        chk("t2_pc", wv_t'(bus.pcOut), wv_t'(16'h0040));
        chk("t2_snapDone", wv_t'(bus.snapDone), wv_t'(1'b1));
        chk("t2_frameCnt", wv_t'(bus.frameCnt), wv_t'(1));
        cyc(2);

        // Timeout: no cpuValid for a whole wait window, then recovery on the next frame.
        r0 = bus.regOut;
        bus.regIn = rnd_bus();
        bus.vgaVs = 1'b0;
        cyc(1);
        bus.vgaVs = 1'b1;
        cyc(10);
        chk("t3_stale_set", wv_t'(bus.stale), wv_t'(1'b1));
        chk("t3_regs_held", bus.regOut, r0);
        capture_frame(2);
        chk("t3_stale_clr", wv_t'(bus.stale), wv_t'(1'b0));
        chk("t3_regs_new", bus.regOut, bus.regIn);

        // Freeze across two frames with the CPU state changing underneath.
        bus.freezeIn = 1'b1;
        cyc(1);
        r0 = bus.regOut; p0 = bus.pcOut; fc0 = bus.frameCnt; ns0 = n_snap;
        for (int f = 0; f < 2; f++) begin
            bus.regIn = rnd_bus();
            bus.pcIn = RW'($urandom);
            bus.vgaVs = 1'b0;
            bus.cpuValid = 1'b1;
            cyc(2);
            bus.vgaVs = 1'b1;
            cyc(6);
        end
        bus.cpuValid = 1'b0;
        chk("t4_frozen", wv_t'(bus.frozen), wv_t'(1'b1));
        chk("t4_regs", bus.regOut, r0);
        chk("t4_pc", wv_t'(bus.pcOut), wv_t'(p0));
        chk("t4_frameCnt", wv_t'(bus.frameCnt), wv_t'(16'(fc0 + 16'd2)));
        chk("t4_no_snap", wv_t'(n_snap), wv_t'(ns0));
        bus.freezeIn = 1'b0;
        cyc(2);

        // Freeze and cpuValid rising together while armed: no capture, back to idle.
        bus.regIn = ~bus.regOut;
        r0 = bus.regOut; ns0 = n_snap;
        bus.vgaVs = 1'b0;
        cyc(1);
        bus.vgaVs = 1'b1;
        bus.freezeIn = 1'b1;
        bus.cpuValid = 1'b1;
        cyc(1);
        bus.freezeIn = 1'b0;
        cyc(3);
        bus.cpuValid = 1'b0;
        chk("t5_regs", bus.regOut, r0);
        chk("t5_no_snap", wv_t'(n_snap), wv_t'(ns0));
        cyc(1);

        // Only reg3 changes between two captures.
        bus.regIn = rnd_bus();
        capture_frame(1);
        bus.regIn[3*RW +: RW] = bus.regIn[3*RW +: RW] ^ 16'h00FF;
        capture_frame(1);
`ifdef DIFF_HIGHLIGHT_EN
        exp_mask = 10'b0000001000;
`else
        exp_mask = '0;
`endif
        chk("t6_mask", wv_t'(bus.changedMask), wv_t'(exp_mask));

        // Asynchronous reset while armed with a nonzero snapshot.
        bus.vgaVs = 1'b0;
        cyc(1);
        bus.vgaVs = 1'b1;
        cyc(2);
        #3 rst = 1'b0;
        #1 chk_all_zero("t1_async");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        ns0 = n_snap;
        bus.cpuValid = 1'b1;
        cyc(3);
        bus.cpuValid = 1'b0;
        chk("t1_idle_after", wv_t'(n_snap), wv_t'(ns0));

        // Random frames: short frames re-arm while waiting, long ones time out, freeze toggles.
        for (int f = 0; f < 120; f++) begin
            len = $urandom_range(4, 24);
            pv  = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) bus.freezeIn = ~bus.freezeIn;
            for (int c = 0; c < len; c++) begin
                bus.vgaVs = (c < 2) ? 1'b0 : 1'b1;
                bus.cpuValid = ($urandom_range(0, 7) < pv);
                if ($urandom_range(0, 3) == 0) begin
                    idx = $urandom_range(0, NREG - 1);
                    bus.regIn[idx*RW +: RW] = RW'($urandom);
                end
                if ($urandom_range(0, 3) == 0) bus.pcIn = RW'($urandom);
                if ($urandom_range(0, 40) == 0) bus.freezeIn = ~bus.freezeIn;
                cyc(1);
            end
        end
        bus.freezeIn = 1'b0;
        bus.cpuValid = 1'b0;
        bus.vgaVs = 1'b1;
        cyc(3);

        chk("queue_drained", wv_t'(exp_q.size()), '0);
        chk("captures_seen", wv_t'(n_snap > 5), wv_t'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
